// File: rtl/synch_fifo_core_pkg.sv
// ---------------------------------------------------------------------------
// synch_fifo_core_pkg
//
// Shared constants, types and helpers for the single-clock FIFO slice.
// Every other file in this block imports this package, so the storage
// geometry (8 entries x 16 bits) is defined in exactly one place.
//
// Contents:
//   FIFO_DATA_WIDTH   width of one stored word
//   FIFO_DEPTH        number of entries (power of two)
//   FIFO_ADDR_WIDTH   pointer width, log2(FIFO_DEPTH)
//   FIFO_COUNT_WIDTH  occupancy width, able to hold 0..FIFO_DEPTH
//   data_t/addr_t/count_t  convenience vector types
//   calc_count_nxt()  occupancy after one edge given the accepted ops
//   calc_room()       free entries for a given occupancy
// ---------------------------------------------------------------------------
package synch_fifo_core_pkg;

    localparam int FIFO_DATA_WIDTH  = 16;
    localparam int FIFO_DEPTH       = 8;
    localparam int FIFO_ADDR_WIDTH  = $clog2(FIFO_DEPTH);
    // One extra bit so that a completely full FIFO (count == DEPTH) is
    // distinguishable from an empty one.
    localparam int FIFO_COUNT_WIDTH = FIFO_ADDR_WIDTH + 1;

    typedef logic [FIFO_DATA_WIDTH-1:0]  data_t;
    typedef logic [FIFO_ADDR_WIDTH-1:0]  addr_t;
    typedef logic [FIFO_COUNT_WIDTH-1:0] count_t;

    localparam count_t FIFO_DEPTH_COUNT = count_t'(FIFO_DEPTH);

    // Occupancy after the coming edge. The accept terms are already gated
    // by the registered flags, so a write is never counted when full and a
    // read is never counted when empty; the result therefore stays inside
    // 0..DEPTH without any saturation logic. A simultaneous write and read
    // leaves the count where it is.
    function automatic count_t calc_count_nxt(input count_t count,
                                              input logic   wr_acc,
                                              input logic   rd_acc);
        count_t result;
        result = count;
        case ({wr_acc, rd_acc})
            2'b10:   result = count + count_t'(1);
            2'b01:   result = count - count_t'(1);
            default: result = count;
        endcase
        return result;
    endfunction

    // Free entries for a given occupancy. Kept next to calc_count_nxt so
    // that data_avail + room_avail == DEPTH holds by construction.
    function automatic count_t calc_room(input count_t count);
        return FIFO_DEPTH_COUNT - count;
    endfunction

endpackage : synch_fifo_core_pkg

// File: rtl/synch_fifo_core_if.sv
// ---------------------------------------------------------------------------
// synch_fifo_core_if
//
// Producer/consumer side bus of the FIFO. Clock and reset are not carried
// here; they stay plain ports on the FIFO itself.
//
// Signals:
//   wr_en        write request (producer -> FIFO)
//   write_data   word to store on an accepted write (producer -> FIFO)
//   rd_en        read request (consumer -> FIFO)
//   read_data    registered read data, one cycle after an accepted read
//   full/empty   registered occupancy flags
//   full_nxt     value full will take after the next edge (combinational)
//   empty_nxt    value empty will take after the next edge (combinational)
//   room_avail   registered free-entry count
//   data_avail   registered occupancy
//   memory_wire  head entry mem[rd_ptr], debug view (combinational)
//
// Modports:
//   master  the environment (producer + consumer) driving the requests
//   slave   the FIFO answering them
// ---------------------------------------------------------------------------
interface synch_fifo_core_if
    import synch_fifo_core_pkg::*;
#(
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int COUNT_WIDTH = FIFO_COUNT_WIDTH
) ();

    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  write_data;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  read_data;
    logic                   full;
    logic                   empty;
    logic                   full_nxt;
    logic                   empty_nxt;
    logic [COUNT_WIDTH-1:0] room_avail;
    logic [COUNT_WIDTH-1:0] data_avail;
    logic [DATA_WIDTH-1:0]  memory_wire;

    modport master (
        output wr_en,
        output write_data,
        output rd_en,
        input  read_data,
        input  full,
        input  empty,
        input  full_nxt,
        input  empty_nxt,
        input  room_avail,
        input  data_avail,
        input  memory_wire
    );

    modport slave (
        input  wr_en,
        input  write_data,
        input  rd_en,
        output read_data,
        output full,
        output empty,
        output full_nxt,
        output empty_nxt,
        output room_avail,
        output data_avail,
        output memory_wire
    );

endinterface : synch_fifo_core_if

// File: rtl/synch_fifo_core_fifo_mem_2p.sv
// ---------------------------------------------------------------------------
// fifo_mem_2p
//
// Storage array for the FIFO: DEPTH x DATA_WIDTH registers with one
// synchronous write port and one asynchronous read port. It holds no
// pointers or flags; the controller decides when a write is allowed.
// The array is deliberately not reset, so after reset it still contains
// whatever was written before.
//
// Ports:
//   clk      rising-edge clock for the write port
//   wr_en    write strobe (already qualified by the controller)
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  mem[rd_addr], combinational
// ---------------------------------------------------------------------------
module fifo_mem_2p
    import synch_fifo_core_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per edge, no reset so the array maps onto
    // plain registers or distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is asynchronous; the controller registers the value itself
    // when a read is accepted, and exposes it raw as the head-entry view.
    assign rd_data = mem[rd_addr];

endmodule : fifo_mem_2p

// File: rtl/synch_fifo_core.sv
// ---------------------------------------------------------------------------
// synch_fifo_core
//
// Single-clock synchronous FIFO, 8 entries x 16 bits. Holds the read and
// write pointers, the occupancy count and all registered status outputs;
// the storage itself lives in fifo_mem_2p.
//
// Ports:
//   clk    rising-edge clock, all state changes here
//   reset  asynchronous active-high reset (released synchronously by the
//          environment); clears pointers, count, read_data and flags but
//          not the memory contents
//   bus    synch_fifo_core_if.slave
//            wr_en/write_data  write request, accepted only when full = 0
//            rd_en             read request, accepted only when empty = 0
//            read_data         registered, valid the cycle after the read
//            full/empty        registered occupancy flags
//            full_nxt/empty_nxt  flags after the next edge (combinational)
//            room_avail        DEPTH - occupancy (registered)
//            data_avail        occupancy (registered)
//            memory_wire       mem[rd_ptr], head entry debug view
// ---------------------------------------------------------------------------
module synch_fifo_core
    import synch_fifo_core_pkg::*;
#(
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int DEPTH       = FIFO_DEPTH,
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int COUNT_WIDTH = FIFO_COUNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    synch_fifo_core_if.slave  bus
);

    localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  PTR_ONE     = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_nxt;

    logic                   wr_acc;
    logic                   rd_acc;

    logic                   full_q;
    logic                   empty_q;
    logic [COUNT_WIDTH-1:0] data_avail_q;
    logic [COUNT_WIDTH-1:0] room_avail_q;
    logic [DATA_WIDTH-1:0]  read_data_q;
    logic [DATA_WIDTH-1:0]  head_data;

    // Requests are qualified against the registered flags, never against
    // the predictions. That is what makes a write on a full FIFO a no-op
    // even while a read is draining an entry in the same cycle, and a read
    // on an empty FIFO a no-op even while a write is filling it.
    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    // Next occupancy; shared by the registered flags and the predictions
    // so the two can never disagree.
    assign count_nxt = calc_count_nxt(count, wr_acc, rd_acc);

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.write_data),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    // Pointers advance only on accepted operations and wrap naturally at
    // the pointer width, which is why DEPTH has to be a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy and the status outputs derived from it are all loaded from
    // count_nxt on the same edge, so they always describe the same state
    // and data_avail + room_avail stays equal to DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            data_avail_q <= '0;
            room_avail_q <= DEPTH_COUNT;
        end else begin
            count        <= count_nxt;
            full_q       <= (count_nxt == DEPTH_COUNT);
            empty_q      <= (count_nxt == '0);
            data_avail_q <= count_nxt;
            room_avail_q <= calc_room(count_nxt);
        end
    end

    // Read data register: captures the head entry on an accepted read and
    // otherwise holds, so a read attempted on an empty FIFO leaves the last
    // delivered word visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
        end else if (rd_acc) begin
            read_data_q <= head_data;
        end
    end

    assign bus.read_data   = read_data_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.data_avail  = data_avail_q;
    assign bus.room_avail  = room_avail_q;
    assign bus.full_nxt    = (count_nxt == DEPTH_COUNT);
    assign bus.empty_nxt   = (count_nxt == '0);
    assign bus.memory_wire = head_data;

endmodule : synch_fifo_core

// File: tb/tb_synch_fifo_core.sv
// ---------------------------------------------------------------------------
// tb_synch_fifo_core
//
// Directed bench for synch_fifo_core. Inputs are driven 1 time unit after
// the rising edge, combinational predictions are sampled 1 unit after the
// inputs settle, and registered outputs are sampled 1 unit after the edge.
// ---------------------------------------------------------------------------
module tb_synch_fifo_core;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    synch_fifo_core_if fifo_bus ();

    synch_fifo_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fifo_bus)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive the request inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic w, input logic [15:0] d,
                                 input logic r);
        fifo_bus.wr_en      = w;
        fifo_bus.write_data = d;
        fifo_bus.rd_en      = r;
        #1;
    endtask

    // Advance one edge, then check the invariants on the new state.
    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("avail_sum",
                    32'(fifo_bus.data_avail) + 32'(fifo_bus.room_avail), 32'd8);
        checkOutput("full_and_empty",
                    {31'b0, fifo_bus.full & fifo_bus.empty}, 32'd0);
    endtask

    task automatic doOp(input logic w, input logic [15:0] d, input logic r);
        applyStimulus(w, d, r);
        tick();
    endtask

    logic [15:0] val;
    logic [15:0] vals [8];

    initial begin
        reset = 1'b1;
        fifo_bus.wr_en      = 1'b0;
        fifo_bus.write_data = '0;
        fifo_bus.rd_en      = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_empty",      32'(fifo_bus.empty),      32'd1);
        checkOutput("rst_full",       32'(fifo_bus.full),       32'd0);
        checkOutput("rst_data_avail", 32'(fifo_bus.data_avail), 32'd0);
        checkOutput("rst_room_avail", 32'(fifo_bus.room_avail), 32'd8);
        checkOutput("rst_read_data",  32'(fifo_bus.read_data),  32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_empty_nxt",  32'(fifo_bus.empty_nxt),  32'd1);
        checkOutput("rst_full_nxt",   32'(fifo_bus.full_nxt),   32'd0);

        // ---------------- single write / read ----------------
        doOp(1'b1, 16'h0024, 1'b0);
        checkOutput("single_wr_empty", 32'(fifo_bus.empty),       32'd0);
        checkOutput("single_wr_avail", 32'(fifo_bus.data_avail),  32'd1);
        checkOutput("single_wr_room",  32'(fifo_bus.room_avail),  32'd7);
        checkOutput("single_wr_head",  32'(fifo_bus.memory_wire), 32'h0024);
        doOp(1'b0, 16'h0000, 1'b1);
        checkOutput("single_rd_data",  32'(fifo_bus.read_data),   32'h0024);
        checkOutput("single_rd_empty", 32'(fifo_bus.empty),       32'd1);

        // ---------------- fill: 0xFF down to 0xF7, 9 writes ----------------
        // Stored words are 0xFF..0xF8; the 9th (0xF7) must be dropped.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 16'(16'h00FF - i), 1'b0);
            if (i == 6) checkOutput("fill_full_nxt_7", 32'(fifo_bus.full_nxt), 32'd0);
            if (i >= 7) checkOutput("fill_full_nxt_8", 32'(fifo_bus.full_nxt), 32'd1);
            tick();
            if (i == 7) begin
                checkOutput("fill_full",  32'(fifo_bus.full),       32'd1);
                checkOutput("fill_room",  32'(fifo_bus.room_avail), 32'd0);
                checkOutput("fill_avail", 32'(fifo_bus.data_avail), 32'd8);
            end
        end
        checkOutput("fill_drop_full",  32'(fifo_bus.full),       32'd1);
        checkOutput("fill_drop_avail", 32'(fifo_bus.data_avail), 32'd8);

        // ---------------- drain past empty: 20 reads ----------------
        for (int i = 0; i < 20; i++) begin
            doOp(1'b0, 16'h0000, 1'b1);
            if (i < 8) checkOutput("drain_data", 32'(fifo_bus.read_data), 32'(16'h00FF - i));
            if (i == 7) checkOutput("drain_empty_at_8", 32'(fifo_bus.empty), 32'd1);
        end
        checkOutput("drain_hold_data",  32'(fifo_bus.read_data),  32'h00F8);
        checkOutput("drain_hold_avail", 32'(fifo_bus.data_avail), 32'd0);
        checkOutput("drain_hold_room",  32'(fifo_bus.room_avail), 32'd8);
        checkOutput("drain_hold_empty", 32'(fifo_bus.empty),      32'd1);
        // rd_ptr must still be 1: first fill word (0xFF) sat at slot 1.
        checkOutput("drain_ptr_head",   32'(fifo_bus.memory_wire), 32'h00FF);

        // ---------------- pointer wrap: 3 x 8 write/read pairs ----------------
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                val = 16'($urandom);
                doOp(1'b1, val, 1'b0);
                checkOutput("wrap_head", 32'(fifo_bus.memory_wire), 32'(val));
                doOp(1'b0, 16'h0000, 1'b1);
                checkOutput("wrap_data", 32'(fifo_bus.read_data), 32'(val));
            end
        end
        checkOutput("wrap_empty", 32'(fifo_bus.empty), 32'd1);

        // ---------------- simultaneous at count = 3 ----------------
        vals[0] = 16'hA001; vals[1] = 16'hA002; vals[2] = 16'hA003; vals[3] = 16'hA004;
        for (int i = 0; i < 3; i++) doOp(1'b1, vals[i], 1'b0);
        checkOutput("sim3_pre_avail", 32'(fifo_bus.data_avail), 32'd3);
        doOp(1'b1, vals[3], 1'b1);
        checkOutput("sim3_avail", 32'(fifo_bus.data_avail),  32'd3);
        checkOutput("sim3_data",  32'(fifo_bus.read_data),   32'hA001);
        checkOutput("sim3_head",  32'(fifo_bus.memory_wire), 32'hA002);
        for (int i = 1; i < 4; i++) begin
            doOp(1'b0, 16'h0000, 1'b1);
            checkOutput("sim3_order", 32'(fifo_bus.read_data), 32'(vals[i]));
        end
        checkOutput("sim3_empty", 32'(fifo_bus.empty), 32'd1);

        // ---------------- simultaneous at empty ----------------
        applyStimulus(1'b1, 16'hB001, 1'b1);
        checkOutput("sime_empty_nxt", 32'(fifo_bus.empty_nxt), 32'd0);
        tick();
        checkOutput("sime_avail", 32'(fifo_bus.data_avail), 32'd1);
        checkOutput("sime_hold",  32'(fifo_bus.read_data),  32'hA004);
        checkOutput("sime_empty", 32'(fifo_bus.empty),      32'd0);
        doOp(1'b0, 16'h0000, 1'b1);
        checkOutput("sime_data",  32'(fifo_bus.read_data),  32'hB001);

        // ---------------- simultaneous at full ----------------
        for (int i = 0; i < 8; i++) doOp(1'b1, 16'(16'hC000 + i), 1'b0);
        checkOutput("simf_pre_full", 32'(fifo_bus.full), 32'd1);
        applyStimulus(1'b1, 16'hDEAD, 1'b1);
        checkOutput("simf_full_nxt", 32'(fifo_bus.full_nxt), 32'd0);
        tick();
        checkOutput("simf_data",  32'(fifo_bus.read_data),  32'hC000);
        checkOutput("simf_avail", 32'(fifo_bus.data_avail), 32'd7);
        checkOutput("simf_full",  32'(fifo_bus.full),       32'd0);
        for (int i = 1; i < 8; i++) begin
            doOp(1'b0, 16'h0000, 1'b1);
            checkOutput("simf_order", 32'(fifo_bus.read_data), 32'(16'hC000 + i));
        end
        checkOutput("simf_empty", 32'(fifo_bus.empty), 32'd1);

        // ---------------- async reset with count = 5 ----------------
        for (int i = 0; i < 5; i++) doOp(1'b1, 16'(16'hE000 + i), 1'b0);
        checkOutput("mid_pre_avail", 32'(fifo_bus.data_avail), 32'd5);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_empty", 32'(fifo_bus.empty),      32'd1);
        checkOutput("mid_rst_full",  32'(fifo_bus.full),       32'd0);
        checkOutput("mid_rst_avail", 32'(fifo_bus.data_avail), 32'd0);
        checkOutput("mid_rst_room",  32'(fifo_bus.room_avail), 32'd8);
        checkOutput("mid_rst_data",  32'(fifo_bus.read_data),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pointers restarted at 0: a fresh word comes straight back.
        doOp(1'b1, 16'h0055, 1'b0);
        doOp(1'b0, 16'h0000, 1'b1);
        checkOutput("post_rst_data",  32'(fifo_bus.read_data), 32'h0055);
        checkOutput("post_rst_empty", 32'(fifo_bus.empty),     32'd1);

        applyStimulus(1'b0, 16'h0000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_synch_fifo_core
